ahblite_mem_slave: RTL and testbench
====================================

Name: ahblite_mem_slave

Overview:
- AHB-Lite responder (slave end of the bus) backing a word-addressed internal memory array.
- Sits on one slave port of the CoreAHBLite matrix and consumes the HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HREADY signals that the slave stage drives.
- Supports a parameterised number of wait states, byte/halfword/word writes, and a two-cycle ERROR response for illegal accesses.
- Used as a test target and as a scratchpad RAM behind the MiV core.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words; power of 2, range 4..4096.
- WAIT_STATES, 0, wait cycles inserted in each OKAY data phase; range 0..7.

Ports:
- HCLK  input  1  bus clock; all state updates on the rising edge.
- HRESETN  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select from the interconnect.
- HADDR  input  32  byte address; only bits [log2(MEM_DEPTH)+1:0] decoded, upper bits checked for range.
- HTRANS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HSIZE  input  3  000 byte, 001 halfword, 010 word; larger values are illegal.
- HWRITE  input  1  1 = write.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  bus-wide ready; an address phase completes only when this is 1.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- HRDATA  output  32  read data.

Behaviour:
- Reset (async assert, sync release): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, captured controls cleared. Memory contents are not reset.
- Address-phase capture:
  - Condition: HSEL & HREADY & HTRANS[1] on a rising edge.
  - Registers HADDR, HSIZE, HWRITE.
  - Classifies the access as legal or illegal.
- Illegal access, any of:
  - HADDR >= 4*MEM_DEPTH;
  - HSIZE > 010;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=00.
- IDLE/BUSY, or HSEL=0, with HREADY=1: the next cycle is a zero-wait OKAY (HREADYOUT=1, HRESP=0). Memory is untouched.
- FSM states and transitions:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Legal capture with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Legal capture with WAIT_STATES=0 -> IDLE; this is a single-cycle data phase.
    - Illegal capture -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 0 -> LAST.
  - LAST: HREADYOUT=1, HRESP=0. Completes the data phase; new captures are evaluated in this cycle exactly as in IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Captures are evaluated as in IDLE.
  - ERROR responses never insert WAIT_STATES.
- Write:
  - Memory is updated at the edge ending the data phase: the cycle with HREADYOUT=1 in IDLE(zero-wait)/LAST state.
  - HWDATA is sampled on that edge.
  - Little-endian byte enables:
    - byte: lane HADDR[1:0];
    - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
    - word: all four lanes.
  - Unselected lanes are preserved.
  - No memory update ever occurs on an ERROR.
- Read:
  - HRDATA = mem[captured word address] combinationally throughout the data phase.
  - The full word is returned regardless of HSIZE.
  - HRDATA=0 outside read data phases and during ERR1/ERR2.
- Read-after-write to the same address in back-to-back transfers returns the new data; the write lands on the edge before the read data phase.
- A capture in the final data-phase cycle (pipelined transfer) starts the next data phase with no bubble.
- HREADY=0 with HSEL=1 (another slave stalling): no capture, FSM unchanged.
- Reset asserted mid-transfer: outputs return to reset values immediately; any write not yet at its completing edge is dropped.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> write completes in 1 cycle; read data phase HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0.
- WAIT_STATES=3: read @0x0 -> HREADYOUT low for exactly 3 cycles, high on the 4th cycle with valid HRDATA.
- Byte write 0xAA @0x13 over word 0x11223344 at 0x10 -> readback 0xAA223344. Halfword write 0xBBCC @0x10 -> readback 0xAA22BBCC.
- Illegal accesses: word @0x2, halfword @0x1, HSIZE=011, address 4*MEM_DEPTH -> each gives HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1; a following read of the target word shows it unchanged.
- Mixed stream: NONSEQ, BUSY, IDLE, HSEL=0, HREADY=0 stall cycles interleaved -> only NONSEQ/SEQ with HREADY=1 cause accesses; IDLE/BUSY give zero-wait OKAY.
- Assert HRESETN during WAIT of a write -> HREADYOUT=1, HRESP=0 immediately; a later read shows the old data.

Source files
------------

// File: rtl/ahblite_mem_slave.sv
// AHB-Lite slave backed by a word-organised RAM, with configurable OKAY wait states
// and a two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahblite_mem_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            act_q, act_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     mem_q [MEM_DEPTH];

    logic            accept;
    logic            capture;
    logic            legal;
    logic            wr_fire;
    logic [3:0]      be;

    // Every cycle with HREADYOUT=1 ends the current data phase and may take a new address phase.
    assign accept  = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
    assign capture = accept && HSEL && HREADY && HTRANS[1];
    assign wr_fire = accept && act_q && wr_q;

    always_comb begin
        legal = 1'b1;
        if (|HADDR[31:AW+2])                           legal = 1'b0;
        if (HSIZE > 3'b010)                            legal = 1'b0;
        if ((HSIZE == 3'b001) && HADDR[0])             legal = 1'b0;
        if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) legal = 1'b0;
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            act_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_LAST, S_ERR2: begin
                state_d = S_IDLE;
                if (capture) begin
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_LAST;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // act_q marks a legal data phase in flight; illegal captures never set it.
    always_comb begin
        act_d  = act_q;
        wr_d   = wr_q;
        size_d = size_q;
        addr_d = addr_q;
        if (capture) begin
            act_d  = legal;
            wr_d   = HWRITE;
            size_d = HSIZE[1:0];
            addr_d = HADDR[AW+1:0];
        end else if (accept) begin
            act_d  = 1'b0;
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'd0;
        case (state_q)
            S_WAIT:  HREADYOUT = 1'b0;
            S_ERR1:  begin HREADYOUT = 1'b0; HRESP = 1'b1; end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
        if (act_q && !wr_q) HRDATA = mem_q[addr_q[AW+1:2]];
    end

    always_comb begin
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[addr_q[AW+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahblite_mem_slave.sv
// Directed bench: one zero-wait instance and one three-wait instance, each with its own bus.
module tb_ahblite_mem_slave;
    localparam int DEPTH = 16;
    localparam logic D0 = 1'b0;
    localparam logic D3 = 1'b1;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] BYTE   = 3'b000;
    localparam logic [2:0] HALF   = 3'b001;
    localparam logic [2:0] WORD   = 3'b010;

    logic        clk = 1'b0;
    logic        rstn   [2];
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize  [2];
    logic        hwrite [2];
    logic [31:0] hwdata [2];
    logic        stall  [2];

    logic        hready0, hready1;
    logic        hreadyout0, hreadyout1;
    logic        hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Bench plays the interconnect: bus HREADY follows the slave unless a stall is injected.
    assign hready0 = hreadyout0 & ~stall[0];
    assign hready1 = hreadyout1 & ~stall[1];

    ahblite_mem_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETN(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
        .HREADY(hready0), .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahblite_mem_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETN(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
        .HREADY(hready1), .HREADYOUT(hreadyout1), .HRESP(hresp1), .HRDATA(hrdata1)
    );

    function automatic logic rdy(input logic d);
        return d ? hreadyout1 : hreadyout0;
    endfunction

    function automatic logic rsp(input logic d);
        return d ? hresp1 : hresp0;
    endfunction

    function automatic logic [31:0] rdat(input logic d);
        return d ? hrdata1 : hrdata0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle(input logic d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        haddr[d]  = 32'd0;
        hsize[d]  = WORD;
        hwrite[d] = 1'b0;
        stall[d]  = 1'b0;
    endtask

    task automatic addr_ph(input logic d, input logic [1:0] tr, input logic [31:0] a,
                           input logic [2:0] sz, input logic wr);
        hsel[d]   = 1'b1;
        htrans[d] = tr;
        haddr[d]  = a;
        hsize[d]  = sz;
        hwrite[d] = wr;
    endtask

    task automatic wait_ready(input logic d, input string tag, output int n);
        n = 0;
        while (rdy(d) !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk({tag, "_timeout"}, 32'(rdy(d)), 32'd1);
    endtask

    task automatic do_write(input logic d, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] data, input string tag, output int n);
        addr_ph(d, NONSEQ, a, sz, 1'b1);
        step();
        bus_idle(d);
        hwdata[d] = data;
        wait_ready(d, tag, n);
        chk({tag, "_resp"}, 32'(rsp(d)), 32'd0);
        step();
        hwdata[d] = 32'h0BAD0BAD;
    endtask

    task automatic do_read(input logic d, input logic [31:0] a, input logic [31:0] exp,
                           input string tag, output int n);
        addr_ph(d, NONSEQ, a, WORD, 1'b0);
        step();
        bus_idle(d);
        wait_ready(d, tag, n);
        chk({tag, "_data"}, rdat(d), exp);
        chk({tag, "_resp"}, 32'(rsp(d)), 32'd0);
        step();
        chk({tag, "_idle_data"}, rdat(d), 32'd0);
    endtask

    task automatic do_err(input logic d, input logic [31:0] a, input logic [2:0] sz,
                          input logic wr, input string tag);
        addr_ph(d, NONSEQ, a, sz, wr);
        step();
        bus_idle(d);
        hwdata[d] = 32'hFFFF_FFFF;
        chk({tag, "_err1_ready"}, 32'(rdy(d)), 32'd0);
        chk({tag, "_err1_resp"},  32'(rsp(d)), 32'd1);
        chk({tag, "_err1_data"},  rdat(d),     32'd0);
        step();
        chk({tag, "_err2_ready"}, 32'(rdy(d)), 32'd1);
        chk({tag, "_err2_resp"},  32'(rsp(d)), 32'd1);
        step();
        chk({tag, "_after_resp"}, 32'(rsp(d)), 32'd0);
        hwdata[d] = 32'h0BAD0BAD;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;
        bus_idle(D0);
        bus_idle(D3);
        hwdata[0] = 32'd0;
        hwdata[1] = 32'd0;
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        step();

        chk("rst0_ready", 32'(rdy(D0)), 32'd1);
        chk("rst0_resp",  32'(rsp(D0)), 32'd0);
        chk("rst0_data",  rdat(D0),     32'd0);
        chk("rst3_ready", 32'(rdy(D3)), 32'd1);
        chk("rst3_resp",  32'(rsp(D3)), 32'd0);
        chk("rst3_data",  rdat(D3),     32'd0);

        // Back-to-back write then read of the same word, zero wait states.
        addr_ph(D0, NONSEQ, 32'h10, WORD, 1'b1);
        step();
        hwdata[0] = 32'hDEADBEEF;
        addr_ph(D0, NONSEQ, 32'h10, WORD, 1'b0);
        chk("b2b_wr_ready", 32'(rdy(D0)), 32'd1);
        chk("b2b_wr_resp",  32'(rsp(D0)), 32'd0);
        chk("b2b_wr_data",  rdat(D0),     32'd0);
        step();
        bus_idle(D0);
        hwdata[0] = 32'h0BAD0BAD;
        chk("b2b_rd_data",  rdat(D0),     32'hDEADBEEF);
        chk("b2b_rd_ready", 32'(rdy(D0)), 32'd1);
        chk("b2b_rd_resp",  32'(rsp(D0)), 32'd0);
        step();
        chk("b2b_idle_data", rdat(D0), 32'd0);

        // Pipelined NONSEQ + SEQ writes.
        addr_ph(D0, NONSEQ, 32'h14, WORD, 1'b1);
        step();
        hwdata[0] = 32'h55667788;
        addr_ph(D0, SEQ, 32'h18, WORD, 1'b1);
        step();
        hwdata[0] = 32'h99AABBCC;
        bus_idle(D0);
        step();
        hwdata[0] = 32'h0BAD0BAD;
        do_read(D0, 32'h14, 32'h55667788, "pipe_rd14", n);
        do_read(D0, 32'h18, 32'h99AABBCC, "pipe_rd18", n);

        // Byte and halfword lanes; unselected lanes carry junk that must not land.
        do_write(D0, 32'h10, WORD, 32'h11223344, "lane_word", n);
        do_write(D0, 32'h13, BYTE, 32'hAA5A5A5A, "lane_byte", n);
        do_read(D0, 32'h10, 32'hAA223344, "lane_byte_rd", n);
        do_write(D0, 32'h10, HALF, 32'h7777BBCC, "lane_half", n);
        do_read(D0, 32'h10, 32'hAA22BBCC, "lane_half_rd", n);

        // Illegal accesses: two-cycle ERROR, no memory update.
        do_write(D0, 32'h00, WORD, 32'h01020304, "base_w0", n);
        do_err(D0, 32'h12, WORD, 1'b1, "err_word_mis");
        do_err(D0, 32'h11, HALF, 1'b1, "err_half_mis");
        do_err(D0, 32'h10, 3'b011, 1'b1, "err_size");
        do_err(D0, 32'h40, WORD, 1'b1, "err_range");
        do_err(D0, 32'h12, WORD, 1'b0, "err_read");
        do_read(D0, 32'h10, 32'hAA22BBCC, "err_keep10", n);
        do_read(D0, 32'h00, 32'h01020304, "err_keep00", n);

        // Mixed stream: BUSY, IDLE, deselected, stalled -- none may access memory.
        hwdata[0] = 32'h0BAD0BAD;
        addr_ph(D0, 2'b01, 32'h10, WORD, 1'b1);
        step();
        chk("mix_busy_ready", 32'(rdy(D0)), 32'd1);
        chk("mix_busy_resp",  32'(rsp(D0)), 32'd0);
        addr_ph(D0, 2'b00, 32'h10, WORD, 1'b1);
        step();
        chk("mix_idle_ready", 32'(rdy(D0)), 32'd1);
        addr_ph(D0, NONSEQ, 32'h10, WORD, 1'b1);
        hsel[0] = 1'b0;
        step();
        chk("mix_nosel_ready", 32'(rdy(D0)), 32'd1);
        addr_ph(D0, NONSEQ, 32'h10, WORD, 1'b1);
        stall[0] = 1'b1;
        step();
        chk("mix_stall_ready", 32'(rdy(D0)), 32'd1);
        bus_idle(D0);
        step();
        chk("mix_stall_resp", 32'(rsp(D0)), 32'd0);
        do_read(D0, 32'h10, 32'hAA22BBCC, "mix_keep10", n);

        // Three wait states.
        do_write(D3, 32'h00, WORD, 32'hCAFE0001, "ws3_wr", n);
        chk("ws3_wr_waits", 32'(n), 32'd3);
        do_read(D3, 32'h00, 32'hCAFE0001, "ws3_rd", n);
        chk("ws3_rd_waits", 32'(n), 32'd3);

        // Reset during the wait phase of a write drops the write.
        addr_ph(D3, NONSEQ, 32'h00, WORD, 1'b1);
        step();
        bus_idle(D3);
        hwdata[1] = 32'h0BADF00D;
        chk("rstmid_wait1", 32'(rdy(D3)), 32'd0);
        step();
        chk("rstmid_wait2", 32'(rdy(D3)), 32'd0);
        rstn[1] = 1'b0;
        #1;
        chk("rstmid_ready", 32'(rdy(D3)), 32'd1);
        chk("rstmid_resp",  32'(rsp(D3)), 32'd0);
        chk("rstmid_data",  rdat(D3),     32'd0);
        step();
        step();
        rstn[1] = 1'b1;
        step();
        do_read(D3, 32'h00, 32'hCAFE0001, "rstmid_rd", n);
        chk("rstmid_rd_waits", 32'(n), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
